// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute -- execute stage of the 1st-generation pipelined core.
//
// Latches the decoded instruction and its operands into the D/E registers on
// a pipeline advance, then produces the ALU result, the writeback value and
// the store data combinationally from those registers. DIV/DIVU/REM/REMU run
// on a radix-2 restoring divider (one quotient bit per cycle) that holds the
// pipeline by dropping fin while it iterates.
//
// Build option:
//   DIV_EN  defined   -> multi-cycle divider built
//           undefined -> no divider; aluop B..E yields 0 and fin is always 1
//
// Parameters:
//   DIV_CYCLES  divider iterations (quotient bits), default 32
//
// Ports:
//   clk         clock
//   rstn        synchronous active-low reset
//   enable      global pipeline advance (only asserted when every stage fin)
//   fin         outputs valid for the current instruction
//   inst        decoded instruction (aluop, alusrc, imm, jump)
//   pc          PC of inst
//   rdata1      rs1 value (already forwarded)
//   rdata2      rs2 value (already forwarded)
//   inst_out    registered instruction
//   aluresult   ALU output / memory address
//   result      writeback value: pc+4 for jumps, otherwise aluresult
//   rdata1_out  registered rs2 value forwarded to memory as store data
// ---------------------------------------------------------------------------
package execute_pkg;

  // Decoded instruction as produced by decode (only the fields used here).
  typedef struct packed {
    logic [3:0]  aluop;
    logic        alusrc;
    logic [31:0] imm;
    logic        jump;
  } inst_t;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_MUL   = 4'hA;
  localparam logic [3:0] ALU_DIV   = 4'hB;
  localparam logic [3:0] ALU_DIVU  = 4'hC;
  localparam logic [3:0] ALU_REM   = 4'hD;
  localparam logic [3:0] ALU_REMU  = 4'hE;
  localparam logic [3:0] ALU_PASSB = 4'hF;

endpackage

module execute
  import execute_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        fin,
  input  inst_t       inst,
  input  logic [31:0] pc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output inst_t       inst_out,
  output logic [31:0] aluresult,
  output logic [31:0] result,
  output logic [31:0] rdata1_out
);

  inst_t       inst_q;
  logic [31:0] pc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] op_b;
  logic [31:0] div_out;
  logic        capture;

  assign capture = enable && fin;

  // D/E pipeline registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values, independent of block ordering.
    if (!rstn) begin
      inst_q <= '0;
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (capture) begin
      inst_q <= inst;
      pc_q   <= pc;
      a_q    <= rdata1;
      b_q    <= rdata2;
    end
  end

  assign op_b = inst_q.alusrc ? inst_q.imm : b_q;

`ifdef DIV_EN

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  function automatic logic is_div_op(input logic [3:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // Divide by zero and signed overflow finish without iterating.
  function automatic logic is_special(input logic [3:0]  op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == '0) ||
           (is_signed_div(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] special_result(input logic [3:0]  op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
    if ((op == ALU_DIV) || (op == ALU_DIVU)) return (b == '0) ? 32'hFFFF_FFFF : 32'h8000_0000;
    else                                     return (b == '0) ? a : 32'h0;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      quo;      // dividend shifts out, quotient bits shift in
  logic [31:0]      rem;
  logic [31:0]      dvs;
  logic             neg_q;
  logic             neg_r;
  logic [31:0]      in_b;
  logic             in_signed;
  logic             start_div;
  logic [32:0]      shifted;
  logic [32:0]      diff;

  assign in_b      = inst.alusrc ? inst.imm : rdata2;
  assign in_signed = is_signed_div(inst.aluop);
  assign start_div = capture && is_div_op(inst.aluop) && !is_special(inst.aluop, rdata1, in_b);

  // One restoring step: a borrow out of diff means the trial subtract failed.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    unique case (state)
      IDLE:    if (start_div) state_next = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (capture) state_next = start_div ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fin = (state != BUSY);
  end

  // Divider datapath. start_div can only fire while not BUSY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start_div) begin
      cnt   <= CNT_W'(DIV_CYCLES);
      quo   <= in_signed ? abs32(rdata1) : rdata1;
      dvs   <= in_signed ? abs32(in_b) : in_b;
      rem   <= '0;
      neg_q <= in_signed && (rdata1[31] ^ in_b[31]);
      neg_r <= in_signed && rdata1[31];
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      quo <= {quo[30:0], ~diff[32]};
      rem <= diff[32] ? shifted[31:0] : diff[31:0];
    end
  end

  always_comb begin
    div_out = '0;
    if (is_special(inst_q.aluop, a_q, op_b))
      div_out = special_result(inst_q.aluop, a_q, op_b);
    else if ((inst_q.aluop == ALU_DIV) || (inst_q.aluop == ALU_DIVU))
      div_out = neg_q ? -quo : quo;
    else
      div_out = neg_r ? -rem : rem;
  end

`else

  logic unused_cfg;   // DIV_CYCLES has no role without the divider

  assign unused_cfg = (DIV_CYCLES > 0);
  assign fin        = 1'b1;
  assign div_out    = '0;

`endif

  always_comb begin
    aluresult = '0;
    case (inst_q.aluop)
      ALU_ADD:   aluresult = a_q + op_b;
      ALU_SUB:   aluresult = a_q - op_b;
      ALU_AND:   aluresult = a_q & op_b;
      ALU_OR:    aluresult = a_q | op_b;
      ALU_XOR:   aluresult = a_q ^ op_b;
      ALU_SLL:   aluresult = a_q << op_b[4:0];
      ALU_SRL:   aluresult = a_q >> op_b[4:0];
      ALU_SRA:   aluresult = $unsigned($signed(a_q) >>> op_b[4:0]);
      ALU_SLT:   aluresult = {31'b0, $signed(a_q) < $signed(op_b)};
      ALU_SLTU:  aluresult = {31'b0, a_q < op_b};
      ALU_MUL:   aluresult = a_q * op_b;   // low half is sign-agnostic
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: aluresult = div_out;
      ALU_PASSB: aluresult = op_b;
      default:   aluresult = '0;
    endcase
  end

  assign result     = inst_q.jump ? (pc_q + 32'd4) : aluresult;
  assign rdata1_out = b_q;
  assign inst_out   = inst_q;

endmodule

// File: doc/execute.md
# execute

Execute stage of the 1st-generation pipelined core. It sits between decode and the memory stage. On `enable` it latches the decoded instruction and its operands into the D/E pipeline registers, then computes the ALU result, the writeback value and the pass-through store data. The memory stage latches these values on its own `enable` edge. The block also contains a multi-cycle integer divider; while a divide is in flight it holds the pipeline by deasserting `fin`.

## Interface
Parameters:
- `DIV_CYCLES`, default 32. Number of iterations of the radix-2 divider, one quotient bit per cycle.

Ports:
- `clk`: input, 1 bit. Clock.
- `rstn`: input, 1 bit. Reset, synchronous, active-low.
- `enable`: input, 1 bit. Global pipeline advance. Asserted only when every stage reports `fin`.
- `fin`: output, 1 bit. High when the outputs are valid for the current instruction.
- `inst`: input, `Inst`. Decoded instruction. Fields consumed:
  - `aluop[3:0]`
  - `alusrc` (select `imm` as operand B)
  - `imm[31:0]`
  - `jump` (writeback value is `pc+4`)
- `pc`: input, 32 bits. PC of `inst`.
- `rdata1`: input, 32 bits. rs1 value, already forwarded by decode.
- `rdata2`: input, 32 bits. rs2 value, already forwarded by decode.
- `inst_out`: output, `Inst`. Registered `inst`.
- `aluresult`: output, 32 bits. ALU output. This is the memory address for loads and stores.
- `result`: output, 32 bits. Writeback value: `pc_q+4` if `jump`, else `aluresult`.
- `rdata1_out`: output, 32 bits. Registered store data (rs2 value) forwarded to memory.

## Operation
- D/E registers:
  - Capture on `enable && fin`.
  - Registers: `inst_q`, `pc_q`, `a_q=rdata1`, `b_q=rdata2`.
  - Hold otherwise.
  - `rdata1_out = b_q`.
- Operand B = `inst_q.alusrc ? inst_q.imm : b_q`.
- `aluop` encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = B[4:0])
  - 8 SLT (signed), 9 SLTU (result 0 or 1)
  - A MUL (low 32 bits of the signed product, combinational)
  - B DIV, C DIVU, D REM, E REMU
  - F PASSB (output = B, used for LUI)
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY: on a capture edge whose `inst.aluop` is B–E and which is not a special case. The edge loads `cnt=DIV_CYCLES`, |dividend| and |divisor| (absolute values only for the signed ops), and clears the remainder.
  - BUSY: each cycle performs one restoring shift-subtract and decrements `cnt`. Moves to DONE when `cnt` reaches 1.
  - DONE: the final quotient and remainder are held, sign-corrected (quotient negative iff operand signs differ; remainder takes the sign of the dividend).
  - DONE→IDLE, or DONE→BUSY for a back-to-back divide, on the next capture edge.
- Special cases complete with zero busy cycles (the FSM stays in IDLE; the result is combinational):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- `fin = (state != BUSY)`.
- `enable` asserted while BUSY is ignored. No register changes.

## Timing
- Reset (`rstn=0` at a `clk` edge):
  - `inst_q='{default:'0}`, and `pc_q`, `a_q`, `b_q` = 0.
  - State IDLE, `cnt=0`.
  - Output values: `aluresult=0`, `result=0`, `rdata1_out=0`, `fin=1`.
  - Reset mid-divide aborts the divide with no residual state.
- Non-divide instructions: outputs are valid in the cycle after the capture edge, combinational from the D/E registers. `fin` stays 1.
- Divide captured at edge E:
  - `fin=0` for exactly `DIV_CYCLES` cycles, between edges E and E+`DIV_CYCLES`.
  - `fin=1` from edge E+`DIV_CYCLES` onward, with the correct `aluresult`.
  - The next capture can occur at edge E+`DIV_CYCLES`+1 at the earliest.
- `aluresult` and `result` may glitch while BUSY. Consumers sample them only when `fin=1`.
- All arithmetic is modulo 2^32. Shifts use 5 bits.

## Configuration
- `DIV_EN` defined: the divider FSM above is built.
- `DIV_EN` undefined:
  - No divider logic.
  - `aluop` B–E yields `aluresult=0` with `fin` constantly 1.
  - MUL and all other ops are unchanged.

## Test plan
- Reset: hold `rstn=0` for 2 cycles → `fin=1`, `aluresult=result=rdata1_out=0`, `inst_out` all zero.
- Arithmetic and `jump`:
  - ADD 0x7FFFFFFF+1 → `aluresult` 0x80000000.
  - SRA 0x80000000 by 31 → 0xFFFFFFFF.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - PASSB with `alusrc=1`, `imm`=0x12345000 → 0x12345000.
  - `jump=1`, `pc`=0x100 → `result` 0x104.
- DIV -7/2 with `enable` held high:
  - `fin` low for exactly 32 cycles and captures are blocked.
  - Then `aluresult`=0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF with `fin` never dropping.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Back-to-back:
  - DIVU 100/7 followed immediately by REMU 100/7 → 14, then 2.
  - Each result is preceded by 32 cycles of `fin=0`.
  - The ADD after them completes with no stall.
- Reset at cycle 10 of a divide → `fin=1` on the next cycle, then a new ADD 3+4 → 7.
